input_shift_register: RTL and testbench

Input shift register (ISR) for one PIO state machine: the receive-side counterpart of the output shift register. It shifts bits in from the IN source, counts bits accumulated, and pushes completed words into the RX FIFO by autopush or by explicit PUSH. It sits between the state machine's instruction decode and the RX FIFO's push port, and raises a stall request when a blocking push meets a full FIFO.

---
 rtl/input_shift_register_pkg.sv | 11 +
 rtl/input_shift_register_shift_merge.sv | 26 ++
 rtl/input_shift_register.sv | 103 ++++++++++
 tb/tb_input_shift_register.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/input_shift_register_pkg.sv
// Shared ISR/OSR constants and the 0-encodes-32 count decode.
package input_shift_register_pkg;
  localparam int unsigned ISR_WIDTH   = 32;
  localparam logic        SHIFT_LEFT  = 1'b0;
  localparam logic        SHIFT_RIGHT = 1'b1;

  // A 5-bit count field of zero stands for a full 32-bit word.
  function automatic logic [5:0] decode_count(input logic [4:0] c);
    return (c == 5'd0) ? 6'd32 : {1'b0, c};
  endfunction
endpackage

// File: rtl/input_shift_register_shift_merge.sv
// Merges n (1..32) new bits from data_in into the ISR in either direction.
module isr_shift_merge
  import input_shift_register_pkg::*;
(
  input  logic [ISR_WIDTH-1:0] isr,
  input  logic [ISR_WIDTH-1:0] data_in,
  input  logic [5:0]           n,
  input  logic                 dir,
  output logic [ISR_WIDTH-1:0] next
);
  logic [ISR_WIDTH-1:0] w_mask;
  logic [5:0]           w_rsh;

  assign w_mask = (32'h1 << n[4:0]) - 32'h1;
  assign w_rsh  = 6'd32 - n;

  // n == 32 replaces the whole word, avoiding a full-width shift.
  always_comb begin
    if (n[5])
      next = data_in;
    else if (dir == SHIFT_RIGHT)
      next = (isr >> n[4:0]) | (data_in << w_rsh[4:0]);
    else
      next = (isr << n[4:0]) | (data_in & w_mask);
  end
endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: IN shifting, autopush/PUSH into RX FIFO, MOV load.
module input_shift_register
  import input_shift_register_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [4:0]           shift_count,
  input  logic [ISR_WIDTH-1:0] data_in,
  input  logic                 shiftdir,
  input  logic                 autopush,
  input  logic [4:0]           push_thresh,
  input  logic                 push_req,
  input  logic                 push_iffull,
  input  logic                 push_block,
  input  logic                 mov_en,
  input  logic [ISR_WIDTH-1:0] mov_in,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [ISR_WIDTH-1:0] fifo_data,
  output logic [ISR_WIDTH-1:0] mov_out,
  output logic [5:0]           shift_counter,
  output logic                 stall,
  output logic                 rx_dropped
);
  logic [ISR_WIDTH-1:0] r_isr, w_isr_nxt, w_shifted;
  logic [5:0]           r_cnt, w_cnt_nxt, w_n, w_thresh, w_sat_cnt;
  logic [6:0]           w_sum;
  logic                 r_drop, w_drop, w_push, w_stall;

  assign w_n      = decode_count(shift_count);
  assign w_thresh = decode_count(push_thresh);
  assign w_sum    = {1'b0, r_cnt} + {1'b0, w_n};
  assign w_sat_cnt = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];

  isr_shift_merge u_merge (
    .isr     (r_isr),
    .data_in (data_in),
    .n       (w_n),
    .dir     (shiftdir),
    .next    (w_shifted)
  );

  // Priority: MOV over PUSH over IN; a stall leaves all state untouched.
  always_comb begin
    w_isr_nxt = r_isr;
    w_cnt_nxt = r_cnt;
    w_push    = 1'b0;
    w_stall   = 1'b0;
    w_drop    = 1'b0;
    fifo_data = r_isr;
    if (mov_en) begin
      w_isr_nxt = mov_in;
      w_cnt_nxt = 6'd0;
    end else if (push_req) begin
      if (push_iffull && (r_cnt < w_thresh)) begin
        w_push = 1'b0;
      end else if (!fifo_full) begin
        w_push    = 1'b1;
        w_isr_nxt = '0;
        w_cnt_nxt = 6'd0;
      end else if (push_block) begin
        w_stall = 1'b1;
      end else begin
        w_isr_nxt = '0;
        w_cnt_nxt = 6'd0;
        w_drop    = 1'b1;
      end
    end else if (shift_en) begin
      if (autopush && (w_sat_cnt >= w_thresh)) begin
        fifo_data = w_shifted;
        if (!fifo_full) begin
          w_push    = 1'b1;
          w_isr_nxt = '0;
          w_cnt_nxt = 6'd0;
        end else begin
          w_stall = 1'b1;
        end
      end else begin
        w_isr_nxt = w_shifted;
        w_cnt_nxt = w_sat_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isr  <= '0;
      r_cnt  <= 6'd0;
      r_drop <= 1'b0;
    end else begin
      r_isr  <= w_isr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_drop <= w_drop;
    end
  end

  assign fifo_push     = w_push & ~rst;
  assign stall         = w_stall & ~rst;
  assign mov_out       = r_isr;
  assign shift_counter = r_cnt;
  assign rx_dropped    = r_drop;
endmodule

// File: tb/tb_input_shift_register.sv
// Directed bench: expected pushes go into a scoreboard queue checked by a monitor.
module tb_input_shift_register;
  logic        clk = 1'b0, rst = 1'b1;
  logic        shift_en = 0, shiftdir = 0, autopush = 0, push_req = 0;
  logic        push_iffull = 0, push_block = 0, mov_en = 0, fifo_full = 0;
  logic [4:0]  shift_count = 0, push_thresh = 0;
  logic [31:0] data_in = 0, mov_in = 0;
  logic        fifo_push, stall, rx_dropped;
  logic [31:0] fifo_data, mov_out;
  logic [5:0]  shift_counter;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  input_shift_register dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .shift_count(shift_count),
    .data_in(data_in), .shiftdir(shiftdir), .autopush(autopush),
    .push_thresh(push_thresh), .push_req(push_req), .push_iffull(push_iffull),
    .push_block(push_block), .mov_en(mov_en), .mov_in(mov_in),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .mov_out(mov_out), .shift_counter(shift_counter), .stall(stall),
    .rx_dropped(rx_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every push strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_push: got 0x%08h expected none", fifo_data);
      end else begin
        check("push_data", fifo_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    shift_en = 0; push_req = 0; mov_en = 0;
  endtask

  task automatic do_in(input logic [4:0] n, input logic [31:0] d);
    shift_en = 1; shift_count = n; data_in = d;
  endtask

  task automatic do_mov(input logic [31:0] v);
    mov_en = 1; mov_in = v; tick();
  endtask

  task automatic check_state(input string name, input logic [31:0] isr, input logic [5:0] cnt);
    check({name, "_isr"}, mov_out, isr);
    check({name, "_cnt"}, {26'd0, shift_counter}, {26'd0, cnt});
  endtask

  initial begin
    #1;
    check_state("reset", 32'h0, 6'd0);
    check("reset_push", {31'd0, fifo_push}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_drop", {31'd0, rx_dropped}, 32'd0);
    @(posedge clk); #1 rst = 0;

    // Left shift, no autopush
    shiftdir = 0;
    do_in(5'd8, 32'h000000A5); tick();
    do_in(5'd8, 32'hFFFFFF3C); tick();
    check_state("left", 32'h0000A53C, 6'd16);

    // Right shift and 32-bit saturating count
    do_mov(32'h0);
    shiftdir = 1;
    do_in(5'd8, 32'h000000A5); tick();
    check_state("right8", 32'hA5000000, 6'd8);
    do_in(5'd0, 32'hDEADBEEF); tick();
    check_state("right32", 32'hDEADBEEF, 6'd32);

    // Autopush at 16
    do_mov(32'h0);
    shiftdir = 0; autopush = 1; push_thresh = 5'd16;
    do_in(5'd8, 32'h000000A5); tick();
    check_state("ap1", 32'h000000A5, 6'd8);
    do_in(5'd8, 32'h0000003C); exp_q.push_back(32'h0000A53C);
    @(negedge clk);
    check("ap_push", {31'd0, fifo_push}, 32'd1);
    check("ap_stall", {31'd0, stall}, 32'd0);
    tick();
    check_state("ap_after", 32'h0, 6'd0);

    // Autopush blocked by full FIFO for 3 cycles
    do_in(5'd8, 32'h000000A5); tick();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      do_in(5'd8, 32'h0000003C);
      @(negedge clk);
      check("stall_hi", {31'd0, stall}, 32'd1);
      check("stall_nopush", {31'd0, fifo_push}, 32'd0);
      tick();
      check_state("stall_hold", 32'h000000A5, 6'd8);
    end
    fifo_full = 0;
    do_in(5'd8, 32'h0000003C); exp_q.push_back(32'h0000A53C);
    @(negedge clk);
    check("unstall", {31'd0, stall}, 32'd0);
    tick();
    check_state("unstall_after", 32'h0, 6'd0);
    autopush = 0;

    // Non-blocking PUSH into full FIFO drops the word
    do_mov(32'h00001234);
    fifo_full = 1; push_req = 1; push_block = 0; push_iffull = 0;
    @(negedge clk);
    check("drop_nopush", {31'd0, fifo_push}, 32'd0);
    check("drop_nostall", {31'd0, stall}, 32'd0);
    tick();
    check("drop_pulse", {31'd0, rx_dropped}, 32'd1);
    check_state("drop", 32'h0, 6'd0);
    fifo_full = 0;
    tick();
    check("drop_once", {31'd0, rx_dropped}, 32'd0);

    // PUSH IfFull below threshold 32 is a no-op; plain PUSH then succeeds
    push_thresh = 5'd0;
    do_in(5'd8, 32'h00000077); tick();
    push_req = 1; push_iffull = 1;
    @(negedge clk);
    check("iffull_nostall", {31'd0, stall}, 32'd0);
    tick();
    check_state("iffull", 32'h00000077, 6'd8);
    push_req = 1; push_iffull = 0; exp_q.push_back(32'h00000077);
    tick();
    check_state("push", 32'h0, 6'd0);

    // MOV outranks PUSH and IN in the same cycle
    mov_en = 1; mov_in = 32'h0BADF00D; push_req = 1; do_in(5'd4, 32'hF);
    tick();
    check_state("prio", 32'h0BADF00D, 6'd0);

    // Reset during a blocked PUSH
    fifo_full = 1; push_req = 1; push_block = 1;
    @(negedge clk);
    check("blk_stall", {31'd0, stall}, 32'd1);
    rst = 1; #1;
    check_state("rst_mid", 32'h0, 6'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_push", {31'd0, fifo_push}, 32'd0);
    tick();
    rst = 0; fifo_full = 0; push_block = 0;
    do_mov(32'hCAFEF00D);
    check_state("mov", 32'hCAFEF00D, 6'd0);

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
